clk_div_delay_ctrl: RTL and testbench
=====================================

CLK_DIV_DELAY_CTRL -- requirements
Module: clk_div_delay_ctrl

Interface
REQ-001 SHALL have parameter DIVIDER, default 4, divide ratio of the divided-clock strobe, legal 2..8.
REQ-002 SHALL have parameter NUM_CH, default 4, number of independent delay-line channels, legal 1..16.
REQ-003 SHALL have parameter TAP_W, default 8, width of each channel tap counter.
REQ-004 SHALL have parameter TAP_INIT, default 0, tap value after reset or LOAD.
REQ-005 SHALL have parameter SETTLE, default 4, busy cycles after each accepted tap change, legal 1..15.
REQ-006 SHALL have port CLK_IN  input  1  single clock; all logic is on its rising edge.
REQ-007 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port BIT_SLIP  input  1  one-cycle request to retard the divider phase by one CLK_IN cycle.
REQ-009 SHALL have port DIV_EN  output  1  one-cycle strobe once per divided period.
REQ-010 SHALL have port DIV_PHASE  output  3  current divider phase count.
REQ-011 SHALL have port SLIP_DONE  output  1  one-cycle pulse when a slip has been applied.
REQ-012 SHALL have port DELAY_LINE_LOAD  input  NUM_CH  per-channel reload of TAP_INIT.
REQ-013 SHALL have port DELAY_LINE_MOVE  input  NUM_CH  per-channel one-step tap move request.
REQ-014 SHALL have port DELAY_LINE_DIR  input  NUM_CH  per-channel direction: 1 = increment, 0 = decrement.
REQ-015 SHALL have port TAP_VAL  output  NUM_CH*TAP_W  packed tap counters; channel i at bits [i*TAP_W +: TAP_W].
REQ-016 SHALL have port BUSY  output  NUM_CH  channel in settle window.
REQ-017 SHALL have port DELAY_LINE_OUT_OF_RANGE  output  NUM_CH  sticky flag set on a move that would wrap.

Function
REQ-018 SHALL increment DIV_PHASE by 1 each cycle, wrap from DIVIDER-1 to 0, and assert DIV_EN in the cycle DIV_PHASE equals DIVIDER-1.
REQ-019 SHALL, when BIT_SLIP is sampled high, register a pending slip; at the next DIV_PHASE = DIVIDER-1 cycle, hold DIV_PHASE for one extra cycle, assert DIV_EN only in the second of those two cycles, and pulse SLIP_DONE in that second cycle.
REQ-020 SHALL ignore BIT_SLIP while a slip is pending; one slip is applied per pending request.
REQ-021 SHALL implement a per-channel FSM with states IDLE and SETTLE.
REQ-022 SHALL, in IDLE, on LOAD=1, set the tap to TAP_INIT, clear OUT_OF_RANGE, and enter SETTLE; LOAD has priority over MOVE in the same cycle.
REQ-023 SHALL, in IDLE, on MOVE=1 with LOAD=0, step the tap by ±1 per DIR and enter SETTLE.
REQ-024 SHALL NOT change the tap on a move that would overflow past 2^TAP_W-1 or underflow below 0; instead it SHALL set OUT_OF_RANGE and remain in IDLE.
REQ-025 SHALL make the tap change visible on TAP_VAL one cycle after the request is sampled.
REQ-026 SHALL assert BUSY for exactly SETTLE cycles starting the cycle after acceptance, then return to IDLE.
REQ-027 SHALL, in SETTLE, ignore MOVE; LOAD SHALL be accepted, restart the settle count, and clear OUT_OF_RANGE.
REQ-028 SHALL keep OUT_OF_RANGE asserted until a LOAD or RST.
REQ-029 SHALL keep channels fully independent; simultaneous requests on all channels are all serviced in the same cycle.

Reset
REQ-030 SHALL, on RST high at a clock edge, set DIV_PHASE=0, DIV_EN=0, SLIP_DONE=0, clear any pending slip, set all taps to TAP_INIT, BUSY=0, OUT_OF_RANGE=0, and set all FSMs to IDLE.
REQ-031 SHALL give RST priority over every other input, including in mid-settle and mid-slip.

Structure
REQ-032 SHALL place the FSM state enum and legal-range constants (DIVIDER 2..8, SETTLE 1..15) in shared package clk_div_delay_pkg.
REQ-033 SHALL implement each channel as one instance of sub-module dly_tap_chan, replicated NUM_CH times by generate.
REQ-034 SHALL implement the divider and slip logic at top level, not in dly_tap_chan.

Verification
REQ-035 The bench SHALL check free run with DIVIDER=4 after RST release: DIV_EN high at cycles 3, 7, 11; DIV_PHASE sequence 0,1,2,3,0.
REQ-036 The bench SHALL check a BIT_SLIP pulse at cycle 5: phase 3 held for two cycles; DIV_EN and SLIP_DONE at cycle 8; next DIV_EN at cycle 12.
REQ-037 The bench SHALL check ch0 MOVE with DIR=1 from tap 0: TAP_VAL[7:0]=1 on the next cycle; BUSY[0] high for 4 cycles; a MOVE issued during BUSY is ignored.
REQ-038 The bench SHALL check ch1 MOVE with DIR=0 at tap 0: tap stays 0, OUT_OF_RANGE[1]=1 and stays set; a LOAD then clears the flag and sets tap to TAP_INIT.
REQ-039 The bench SHALL check LOAD and MOVE on all 4 channels in the same cycle: every tap becomes TAP_INIT and all BUSY bits assert together.
REQ-040 The bench SHALL check RST asserted mid-settle with a pending slip: the next cycle shows all outputs at reset values and no SLIP_DONE afterwards.

Source files
------------

// File: rtl/clk_div_delay_pkg.sv
// Shared types and legal parameter ranges for the divided-clock strobe and
// delay-line tap controller.
package clk_div_delay_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } chan_state_e;

  localparam int DIV_MIN      = 2;
  localparam int DIV_MAX      = 8;
  localparam int SETTLE_MIN   = 1;
  localparam int SETTLE_MAX   = 15;
  localparam int PHASE_W      = 3;
  localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/clk_div_delay_ctrl_dly_tap_chan.sv
// One delay-line channel: saturating-checked tap counter with a settle window
// after every accepted tap change.
module dly_tap_chan
  import clk_div_delay_pkg::*;
#(
  parameter int TAP_W    = 8,
  parameter int TAP_INIT = 0,
  parameter int SETTLE   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             move_i,
  input  logic             dir_i,
  output logic [TAP_W-1:0] tap_o,
  output logic             busy_o,
  output logic             oor_o
);

  localparam logic [TAP_W-1:0]        TAP_RST  = TAP_W'(TAP_INIT);
  localparam logic [TAP_W-1:0]        TAP_ONE  = TAP_W'(1);
  localparam logic [TAP_W-1:0]        TAP_MAX  = {TAP_W{1'b1}};
  localparam logic [SETTLE_CNT_W-1:0] CNT_LOAD = SETTLE_CNT_W'(SETTLE - 1);

  if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
    $error("dly_tap_chan: SETTLE out of legal range");
  end

  chan_state_e             state_q;
  logic [TAP_W-1:0]        tap_q;
  logic [SETTLE_CNT_W-1:0] cnt_q;
  logic                    busy_q;
  logic                    oor_q;
  logic                    at_limit_s;

  // A move that would wrap is refused rather than applied.
  assign at_limit_s = dir_i ? (tap_q == TAP_MAX) : (tap_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      tap_q   <= TAP_RST;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_i) begin
            tap_q   <= TAP_RST;
            oor_q   <= 1'b0;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= ST_SETTLE;
          end else if (move_i) begin
            if (at_limit_s) begin
              oor_q <= 1'b1;
            end else begin
              tap_q   <= dir_i ? (tap_q + TAP_ONE) : (tap_q - TAP_ONE);
              cnt_q   <= CNT_LOAD;
              busy_q  <= 1'b1;
              state_q <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          // LOAD restarts the window; moves are dropped until it closes.
          if (load_i) begin
            tap_q <= TAP_RST;
            oor_q <= 1'b0;
            cnt_q <= CNT_LOAD;
          end else if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - SETTLE_CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tap_o  = tap_q;
  assign busy_o = busy_q;
  assign oor_o  = oor_q;

endmodule

// File: rtl/clk_div_delay_ctrl.sv
// Divided-clock strobe generator with bit-slip, plus NUM_CH independent
// delay-line tap channels.
module clk_div_delay_ctrl
  import clk_div_delay_pkg::*;
#(
  parameter int DIVIDER  = 4,
  parameter int NUM_CH   = 4,
  parameter int TAP_W    = 8,
  parameter int TAP_INIT = 0,
  parameter int SETTLE   = 4
) (
  input  logic                    CLK_IN,
  input  logic                    RST,
  input  logic                    BIT_SLIP,
  output logic                    DIV_EN,
  output logic [2:0]              DIV_PHASE,
  output logic                    SLIP_DONE,
  input  logic [NUM_CH-1:0]       DELAY_LINE_LOAD,
  input  logic [NUM_CH-1:0]       DELAY_LINE_MOVE,
  input  logic [NUM_CH-1:0]       DELAY_LINE_DIR,
  output logic [NUM_CH*TAP_W-1:0] TAP_VAL,
  output logic [NUM_CH-1:0]       BUSY,
  output logic [NUM_CH-1:0]       DELAY_LINE_OUT_OF_RANGE
);

  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(DIVIDER - 1);
  localparam logic [PHASE_W-1:0] PH_PRE  = PHASE_W'(DIVIDER - 2);
  localparam logic [PHASE_W-1:0] PH_ONE  = PHASE_W'(1);

  if (DIVIDER < DIV_MIN || DIVIDER > DIV_MAX) begin : g_bad_divider
    $error("clk_div_delay_ctrl: DIVIDER out of legal range");
  end

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               hold_q, hold_d;
  logic               pend_q, pend_d;
  logic               div_en_q, div_en_d;
  logic               slip_done_q, slip_done_d;

  // hold_q marks the first of the two last-phase cycles produced by a slip;
  // the decision is taken one cycle early so DIV_EN can stay registered.
  always_comb begin
    phase_d     = phase_q;
    hold_d      = 1'b0;
    div_en_d    = 1'b0;
    slip_done_d = 1'b0;
    pend_d      = pend_q | BIT_SLIP;
    if (hold_q) begin
      div_en_d    = 1'b1;
      slip_done_d = 1'b1;
    end else if (phase_q == PH_LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PH_ONE;
      if (phase_q == PH_PRE) begin
        if (pend_q) begin
          hold_d = 1'b1;
          pend_d = 1'b0;
        end else begin
          div_en_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      phase_q     <= '0;
      hold_q      <= 1'b0;
      pend_q      <= 1'b0;
      div_en_q    <= 1'b0;
      slip_done_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      div_en_q    <= div_en_d;
      slip_done_q <= slip_done_d;
    end
  end

  assign DIV_PHASE = phase_q;
  assign DIV_EN    = div_en_q;
  assign SLIP_DONE = slip_done_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    dly_tap_chan #(
      .TAP_W    (TAP_W),
      .TAP_INIT (TAP_INIT),
      .SETTLE   (SETTLE)
    ) u_chan (
      .clk_i  (CLK_IN),
      .rst_i  (RST),
      .load_i (DELAY_LINE_LOAD[i]),
      .move_i (DELAY_LINE_MOVE[i]),
      .dir_i  (DELAY_LINE_DIR[i]),
      .tap_o  (TAP_VAL[i*TAP_W +: TAP_W]),
      .busy_o (BUSY[i]),
      .oor_o  (DELAY_LINE_OUT_OF_RANGE[i])
    );
  end

endmodule

// File: tb/tb_clk_div_delay_ctrl.sv
// Self-checking bench: divider vector table, hand-written channel/reset
// sequences, then randomized traffic against a behavioural model.
module tb_clk_div_delay_ctrl;

  localparam int DIV   = 4;
  localparam int NCH   = 4;
  localparam int TW    = 8;
  localparam int TINIT = 0;
  localparam int STL   = 4;

  logic              CLK_IN = 1'b0;
  logic              RST;
  logic              BIT_SLIP;
  logic              DIV_EN;
  logic [2:0]        DIV_PHASE;
  logic              SLIP_DONE;
  logic [NCH-1:0]    DELAY_LINE_LOAD;
  logic [NCH-1:0]    DELAY_LINE_MOVE;
  logic [NCH-1:0]    DELAY_LINE_DIR;
  logic [NCH*TW-1:0] TAP_VAL;
  logic [NCH-1:0]    BUSY;
  logic [NCH-1:0]    DELAY_LINE_OUT_OF_RANGE;

  clk_div_delay_ctrl #(
    .DIVIDER (DIV), .NUM_CH (NCH), .TAP_W (TW), .TAP_INIT (TINIT), .SETTLE (STL)
  ) dut (
    .CLK_IN                  (CLK_IN),
    .RST                     (RST),
    .BIT_SLIP                (BIT_SLIP),
    .DIV_EN                  (DIV_EN),
    .DIV_PHASE               (DIV_PHASE),
    .SLIP_DONE               (SLIP_DONE),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIR          (DELAY_LINE_DIR),
    .TAP_VAL                 (TAP_VAL),
    .BUSY                    (BUSY),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE)
  );

  always #5 CLK_IN = ~CLK_IN;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst;
    bit         slip;
    bit         chk;
    logic [2:0] ph;
    bit         en;
    bit         done;
  } div_vec_t;

  div_vec_t vecs[$];

  // behavioural model state
  int m_ph;
  bit m_en, m_done, m_pend, m_dup;
  int m_tap  [NCH];
  int m_left [NCH];
  bit m_oor  [NCH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(bit r, bit s, bit c, int ph, bit en, bit dn);
    div_vec_t v;
    v.rst  = r;
    v.slip = s;
    v.chk  = c;
    v.ph   = 3'(ph);
    v.en   = en;
    v.done = dn;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(negedge CLK_IN);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  // Model: the divider is a modulo counter that repeats its last phase once
  // per consumed slip; a channel is a tap value plus a remaining-busy count.
  task automatic model_step(input bit r, input bit s, input logic [NCH-1:0] ld,
                            input logic [NCH-1:0] mv, input logic [NCH-1:0] dr);
    int nxt;
    if (r) begin
      m_ph = 0; m_en = 0; m_done = 0; m_pend = 0; m_dup = 0;
      for (int c = 0; c < NCH; c++) begin
        m_tap[c] = TINIT; m_left[c] = 0; m_oor[c] = 0;
      end
    end else begin
      m_done = 0;
      if (m_dup) begin
        m_dup = 0; m_en = 1; m_done = 1;
        m_pend = m_pend | s;
      end else begin
        nxt = (m_ph + 1) % DIV;
        if (nxt == DIV - 1 && m_pend) begin
          m_dup = 1; m_en = 0; m_pend = 0;
        end else begin
          m_en = (nxt == DIV - 1);
          m_pend = m_pend | s;
        end
        m_ph = nxt;
      end
      for (int c = 0; c < NCH; c++) begin
        if (ld[c]) begin
          m_tap[c] = TINIT; m_oor[c] = 0; m_left[c] = STL;
        end else if (m_left[c] > 0) begin
          m_left[c]--;
        end else if (mv[c]) begin
          if (dr[c] ? (m_tap[c] == (1 << TW) - 1) : (m_tap[c] == 0)) begin
            m_oor[c] = 1;
          end else begin
            m_tap[c] = m_tap[c] + (dr[c] ? 1 : -1);
            m_left[c] = STL;
          end
        end
      end
    end
  endtask

  task automatic compare_model(input int cyc);
    logic [NCH*TW-1:0] e_tap;
    logic [NCH-1:0]    e_busy, e_oor;
    for (int c = 0; c < NCH; c++) begin
      e_tap[c*TW +: TW] = TW'(m_tap[c]);
      e_busy[c]         = (m_left[c] > 0);
      e_oor[c]          = m_oor[c];
    end
    check($sformatf("rnd_phase@%0d", cyc), DIV_PHASE, 3'(m_ph));
    check($sformatf("rnd_div_en@%0d", cyc), DIV_EN, m_en);
    check($sformatf("rnd_slip_done@%0d", cyc), SLIP_DONE, m_done);
    check($sformatf("rnd_tap@%0d", cyc), TAP_VAL, e_tap);
    check($sformatf("rnd_busy@%0d", cyc), BUSY, e_busy);
    check($sformatf("rnd_oor@%0d", cyc), DELAY_LINE_OUT_OF_RANGE, e_oor);
  endtask

  initial begin
    int sp[14];
    logic [NCH-1:0] r_ld, r_mv, r_dr;
    bit r_rst, r_slip;

    RST = 1'b1; BIT_SLIP = 1'b0;
    DELAY_LINE_LOAD = '0; DELAY_LINE_MOVE = '0; DELAY_LINE_DIR = '0;
    repeat (2) tick();

    // divider vector table: free run, then a slip requested in cycle 5
    add_vec(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 13; k++) add_vec(0, 0, 1, k % 4, (k % 4) == 3, 0);
    add_vec(1, 0, 0, 0, 0, 0);
    sp = '{0, 1, 2, 3, 0, 1, 2, 3, 3, 0, 1, 2, 3, 0};
    for (int k = 0; k < 14; k++)
      add_vec(0, k == 5, 1, sp[k], (k == 3) || (k == 8) || (k == 12), k == 8);

    foreach (vecs[i]) begin
      tick();
      if (vecs[i].chk) begin
        check($sformatf("vec_phase[%0d]", i), DIV_PHASE, vecs[i].ph);
        check($sformatf("vec_div_en[%0d]", i), DIV_EN, vecs[i].en);
        check($sformatf("vec_slip_done[%0d]", i), SLIP_DONE, vecs[i].done);
      end
      RST      = vecs[i].rst;
      BIT_SLIP = vecs[i].slip;
    end
    tick();

    // ch0 increment, settle window, move during busy ignored
    do_reset();
    check("rst_tap", TAP_VAL, '0);
    check("rst_busy", BUSY, '0);
    check("rst_oor", DELAY_LINE_OUT_OF_RANGE, '0);
    DELAY_LINE_MOVE = 4'b0001; DELAY_LINE_DIR = 4'b0001;
    tick();
    check("ch0_tap_after_move", TAP_VAL[7:0], 8'd1);
    check("ch0_busy_c1", BUSY[0], 1'b1);
    DELAY_LINE_MOVE = 4'b0000;
    tick();
    check("ch0_busy_c2", BUSY[0], 1'b1);
    DELAY_LINE_MOVE = 4'b0001;
    tick();
    check("ch0_busy_c3", BUSY[0], 1'b1);
    check("ch0_tap_move_in_busy", TAP_VAL[7:0], 8'd1);
    DELAY_LINE_MOVE = 4'b0000;
    tick();
    check("ch0_busy_c4", BUSY[0], 1'b1);
    tick();
    check("ch0_busy_c5_clear", BUSY[0], 1'b0);
    check("ch0_tap_final", TAP_VAL[7:0], 8'd1);

    // ch1 underflow, sticky flag, LOAD clears it
    DELAY_LINE_MOVE = 4'b0010; DELAY_LINE_DIR = 4'b0000;
    tick();
    check("ch1_tap_underflow", TAP_VAL[15:8], 8'd0);
    check("ch1_oor_set", DELAY_LINE_OUT_OF_RANGE[1], 1'b1);
    check("ch1_no_busy", BUSY[1], 1'b0);
    DELAY_LINE_MOVE = 4'b0000;
    repeat (3) tick();
    check("ch1_oor_sticky", DELAY_LINE_OUT_OF_RANGE[1], 1'b1);
    DELAY_LINE_LOAD = 4'b0010;
    tick();
    check("ch1_oor_cleared", DELAY_LINE_OUT_OF_RANGE[1], 1'b0);
    check("ch1_tap_init", TAP_VAL[15:8], 8'(TINIT));
    check("ch1_busy_load", BUSY[1], 1'b1);
    DELAY_LINE_LOAD = 4'b0000;
    repeat (4) tick();

    // all channels: move up together, then LOAD+MOVE together
    DELAY_LINE_MOVE = 4'hF; DELAY_LINE_DIR = 4'hF;
    tick();
    DELAY_LINE_MOVE = 4'h0;
    repeat (4) tick();
    check("all_tap_after_move", TAP_VAL, 32'h01010102);
    check("all_busy_idle", BUSY, 4'h0);
    DELAY_LINE_LOAD = 4'hF; DELAY_LINE_MOVE = 4'hF; DELAY_LINE_DIR = 4'hF;
    tick();
    check("all_tap_load_wins", TAP_VAL, '0);
    check("all_busy_together", BUSY, 4'hF);
    DELAY_LINE_LOAD = 4'h0; DELAY_LINE_MOVE = 4'h0;

    // reset mid-settle with a slip pending
    BIT_SLIP = 1'b1;
    tick();
    BIT_SLIP = 1'b0; RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_mid_phase", DIV_PHASE, 3'd0);
    check("rst_mid_div_en", DIV_EN, 1'b0);
    check("rst_mid_slip_done", SLIP_DONE, 1'b0);
    check("rst_mid_tap", TAP_VAL, '0);
    check("rst_mid_busy", BUSY, '0);
    check("rst_mid_oor", DELAY_LINE_OUT_OF_RANGE, '0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("post_rst_no_slip[%0d]", k), SLIP_DONE, 1'b0);
      check($sformatf("post_rst_phase[%0d]", k), DIV_PHASE, 3'(k % DIV));
    end

    // ch2 walked to the top tap, then one more increment is refused
    do_reset();
    for (int k = 0; k < 255; k++) begin
      DELAY_LINE_MOVE = 4'b0100; DELAY_LINE_DIR = 4'b0100;
      tick();
      DELAY_LINE_MOVE = 4'b0000;
      repeat (4) tick();
    end
    check("ch2_tap_max", TAP_VAL[23:16], 8'hFF);
    check("ch2_oor_before", DELAY_LINE_OUT_OF_RANGE[2], 1'b0);
    DELAY_LINE_MOVE = 4'b0100;
    tick();
    DELAY_LINE_MOVE = 4'b0000;
    check("ch2_tap_overflow", TAP_VAL[23:16], 8'hFF);
    check("ch2_oor_overflow", DELAY_LINE_OUT_OF_RANGE[2], 1'b1);
    check("ch2_busy_overflow", BUSY[2], 1'b0);

    // randomized traffic against the model
    for (int i = 0; i <= 800; i++) begin
      tick();
      if (i > 0) compare_model(i);
      r_rst  = (i == 0) || ($urandom_range(0, 149) == 0);
      r_slip = ($urandom_range(0, 5) == 0);
      for (int c = 0; c < NCH; c++) begin
        r_ld[c] = ($urandom_range(0, 15) == 0);
        r_mv[c] = ($urandom_range(0, 2) == 0);
        r_dr[c] = ($urandom_range(0, 2) != 0);
      end
      RST = r_rst; BIT_SLIP = r_slip;
      DELAY_LINE_LOAD = r_ld; DELAY_LINE_MOVE = r_mv; DELAY_LINE_DIR = r_dr;
      model_step(r_rst, r_slip, r_ld, r_mv, r_dr);
    end
    tick();
    compare_model(801);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
